// File: rtl/pc_sequencer.sv
// PC sequencer: selects the next program counter value and issues instruction
// fetches. Handles sequential increment, fetch stalls, branch/jump redirects,
// interrupt entry and return from interrupt.
module pc_sequencer #(
  parameter int unsigned         PC_SIZE = 13,
  parameter logic [PC_SIZE-1:0]  IRQ_VEC = PC_SIZE'(13'h1F00)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] PC_current,
  output logic [PC_SIZE-1:0] PC_next,
  output logic               imem_req,
  input  logic               imem_ready,
  output logic               inst_valid,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_SIZE-1:0] branch_target,
  input  logic               jump,
  input  logic [PC_SIZE-1:0] jump_target,
  input  logic               irq,
  input  logic               eret,
  output logic [PC_SIZE-1:0] epc,
  output logic               irq_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 inst_valid_q, inst_valid_d;
  logic [PC_SIZE-1:0]   epc_q, epc_d;
  logic                 irq_active_q, irq_active_d;
  logic                 advance;

  assign advance = imem_ready & ~stall;

  // Next-state, next-PC and fetch request selection
  always_comb begin
    state_d      = state_q;
    inst_valid_d = 1'b0;
    epc_d        = epc_q;
    irq_active_d = irq_active_q;
    PC_next      = PC_current;
    imem_req     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        // Redirects take effect regardless of stall/imem_ready and drop the fetch
        if (irq && !irq_active_q) begin
          PC_next      = IRQ_VEC;
          epc_d        = PC_current;
          irq_active_d = 1'b1;
          state_d      = ST_FLUSH;
        end else if (eret && irq_active_q) begin
          PC_next      = epc_q;
          irq_active_d = 1'b0;
          state_d      = ST_FLUSH;
        end else if (jump) begin
          PC_next = jump_target;
          state_d = ST_FLUSH;
        end else if (branch_taken) begin
          PC_next = branch_target;
          state_d = ST_FLUSH;
        end else if (advance) begin
          PC_next      = PC_current + PC_SIZE'(1);
          inst_valid_d = 1'b1;
        end
      end

      ST_FLUSH: begin
        state_d = ST_FETCH;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      inst_valid_q <= 1'b0;
      epc_q        <= '0;
      irq_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      epc_q        <= epc_d;
      irq_active_q <= irq_active_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign epc        = epc_q;
  assign irq_active = irq_active_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_SIZE, default 13: width of every PC value.
REQ-002 Parameter IRQ_VEC, default 13'h1F00: interrupt entry address.
REQ-003 clk  input  1: single clock, rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 PC_current  input  PC_SIZE: registered PC from the program counter.
REQ-006 PC_next  output  PC_SIZE: next PC, combinational, loaded by the program counter every clk edge.
REQ-007 imem_req  output  1: instruction fetch request at address PC_current.
REQ-008 imem_ready  input  1: fetch completes this cycle.
REQ-009 inst_valid  output  1: registered; the fetched instruction is usable by decode.
REQ-010 stall  input  1: decode hazard; hold PC.
REQ-011 branch_taken  input  1, branch_target  input  PC_SIZE: conditional redirect.
REQ-012 jump  input  1, jump_target  input  PC_SIZE: unconditional redirect.
REQ-013 irq  input  1: level-sensitive interrupt request.
REQ-014 eret  input  1: return from interrupt.
REQ-015 epc  output  PC_SIZE: saved return PC, registered.
REQ-016 irq_active  output  1: registered; in ISR, further irq masked.

Function
REQ-017 States: IDLE, FETCH, FLUSH; 2-bit state register.
REQ-018 IDLE: imem_req=0, PC_next=PC_current; next state FETCH unconditionally (1-cycle post-reset bubble).
REQ-019 FETCH: imem_req=1; "advance" = imem_ready & ~stall.
REQ-020 PC_next priority in FETCH: irq entry > eret > jump > branch_taken > hold > increment.
REQ-021 irq entry when irq & ~irq_active: PC_next=IRQ_VEC, epc<=PC_current, irq_active<=1, state->FLUSH; taken regardless of stall/imem_ready.
REQ-022 eret when irq_active: PC_next=epc, irq_active<=0, state->FLUSH; eret with irq_active=0 ignored.
REQ-023 jump: PC_next=jump_target, state->FLUSH; branch_taken (jump=0): PC_next=branch_target, state->FLUSH.
REQ-024 Redirects (REQ-021..023) ignore stall and imem_ready; an outstanding fetch is discarded.
REQ-025 hold: if ~advance and no redirect, PC_next=PC_current, state stays FETCH.
REQ-026 increment: on advance, PC_next=PC_current+1 modulo 2^PC_SIZE (13'h1FFF -> 13'h0000).
REQ-027 inst_valid <= 1 in the cycle after an advance without redirect; else 0.
REQ-028 FLUSH: imem_req=0, PC_next=PC_current, inst_valid<=0; next state FETCH; all redirect inputs ignored.
REQ-029 irq asserted during IDLE or FLUSH is not lost: sampled in the following FETCH cycle (level input).
REQ-030 irq while irq_active=1: no effect; re-evaluated after eret's FLUSH.
REQ-031 Simultaneous irq and eret with irq_active=1: eret taken; irq taken at next FETCH if still asserted.

Reset
REQ-032 rst low asynchronously forces: state=IDLE, inst_valid=0, epc=0, irq_active=0; imem_req=0 and PC_next=PC_current while held.
REQ-033 Reset mid-fetch or mid-FLUSH abandons the operation; release resumes at IDLE.

Verification
REQ-034 Release reset, PC_current=0, imem_ready=1 -> 1 cycle imem_req=0, then PC_next 1,2,3..., inst_valid high from 3rd cycle.
REQ-035 PC_current=13'h1FFF, advance -> PC_next=13'h0000.
REQ-036 imem_ready=0 for 3 cycles at PC 13'h0010 -> PC_next=13'h0010 held, inst_valid=0; then 13'h0011.
REQ-037 branch_taken=1, branch_target=13'h0040, with stall=1 -> PC_next=13'h0040, next cycle FLUSH (imem_req=0), then fetch at 13'h0040.
REQ-038 irq=1 at PC 13'h0025 -> PC_next=13'h1F00, epc=13'h0025, irq_active=1; second irq ignored; eret -> PC_next=13'h0025, irq_active=0.
REQ-039 irq, eret, jump same cycle with irq_active=0 -> irq wins, PC_next=IRQ_VEC; eret ignored.
